// File: rtl/lsu_pkg.sv
// Shared types and constants for the RV32I load/store unit.
//   lsu_state_t           : transaction FSM states
//   F3_*                  : funct3 access-size/sign encodings
//   TIMEOUT_W             : width of the bus timeout counter
//   store_strb/store_wdata: store lane placement helpers
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int unsigned TIMEOUT_W = 8;

  // Byte strobes for a store; halfword ignores addr[0] so a misaligned SH
  // lands on its containing aligned half.
  function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] a);
    case (f3)
      F3_B:    store_strb = 4'b0001 << a;
      F3_H:    store_strb = 4'b0011 << {a[1], 1'b0};
      default: store_strb = 4'hF;
    endcase
  endfunction

  // Store data replicated across all lanes; the strobes pick the live ones.
  function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (f3)
      F3_B:    store_wdata = {4{d[7:0]}};
      F3_H:    store_wdata = {2{d[15:0]}};
      default: store_wdata = d;
    endcase
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Data-memory bus between the load/store unit (master) and memory (slave).
//   mem_req/mem_gnt : request held until granted
//   mem_we          : 1 = write
//   mem_addr        : word-aligned byte address
//   mem_wdata/wstrb : lane-replicated store data and byte strobes
//   mem_rvalid      : mem_rdata valid, earliest the cycle after mem_gnt
interface lsu_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/lsu_load_align.sv
// Combinational load alignment and extension.
//   i_rdata   : raw 32-bit word from memory
//   i_funct3  : access size/sign (B, H, W, BU, HU)
//   i_addr_lo : byte offset within the word
//   o_data    : extracted, sign/zero-extended result
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = '0;
    case (i_addr_lo)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
    // Halfword uses addr[1] only: an odd halfword address reads its aligned half.
    w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
  end

  always_comb begin
    o_data = i_rdata;
    case (i_funct3)
      F3_B:    o_data = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_data = {24'h0, w_byte};
      F3_H:    o_data = {{16{w_half[15]}}, w_half};
      F3_HU:   o_data = {16'h0, w_half};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I memory-stage load/store unit. Runs one data-memory transaction per
// accepted load/store, stalling upstream while the bus access is in flight.
//   clk, reset              : clock, synchronous active-high reset
//   ex_valid/mem_read/write : instruction from Execute
//   ex_funct3/addr/store_data
//   lsu_stall               : hold upstream stages
//   lsu_done                : one-cycle completion pulse
//   lsu_load_data           : extended load result (with lsu_done)
//   lsu_err                 : timeout or illegal funct3 (with lsu_done)
//   lsu_misaligned          : misaligned access trapped (with lsu_done)
//   mem                     : lsu_if master port (req/gnt/rvalid bus)
// Build option: LSU_MISALIGN_TRAP_EN -- misaligned H/HU/W accesses skip the
// bus and complete with lsu_misaligned; otherwise the low bits are ignored.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_store_data,
  output logic        lsu_stall,
  output logic        lsu_done,
  output logic [31:0] lsu_load_data,
  output logic        lsu_err,
  output logic        lsu_misaligned,
  lsu_if.master       mem
);

  localparam logic [TIMEOUT_W-1:0] TO_LIMIT = TIMEOUT_W'(TIMEOUT_CYCLES);

  lsu_state_t           r_state, w_next;
  logic [2:0]           r_funct3;
  logic [31:0]          r_addr;
  logic [31:0]          r_data;
  logic                 r_we;
  logic                 r_err;
  logic [31:0]          r_load_data;
  logic [TIMEOUT_W-1:0] r_cnt;

  logic        w_accept;
  logic        w_illegal;
  logic        w_misalign;
  logic        w_timeout;
  logic        w_req;
  logic [31:0] w_ext;

  assign w_accept  = (r_state == IDLE) && ex_valid && (ex_mem_read || ex_mem_write);
  assign w_illegal = (ex_funct3 == 3'b011) || (ex_funct3 == 3'b110) ||
                     (ex_funct3 == 3'b111) || (ex_mem_write && ex_funct3[2]);
  assign w_timeout = (r_cnt == TO_LIMIT);

`ifdef LSU_MISALIGN_TRAP_EN
  logic r_mis;

  always_comb begin
    w_misalign = 1'b0;
    case (ex_funct3)
      F3_H, F3_HU: w_misalign = ex_addr[0];
      F3_W:        w_misalign = |ex_addr[1:0];
      default:     w_misalign = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mis <= 1'b0;
    end else if (w_accept) begin
      r_mis <= w_misalign && !w_illegal;
    end
  end

  assign lsu_misaligned = (r_state == DONE) && r_mis;
`else
  assign w_misalign     = 1'b0;
  assign lsu_misaligned = 1'b0;
`endif

  lsu_load_align u_align (
    .i_rdata   (mem.mem_rdata),
    .i_funct3  (r_funct3),
    .i_addr_lo (r_addr[1:0]),
    .o_data    (w_ext)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    lsu_stall = 1'b0;
    lsu_done  = 1'b0;
    w_req     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          lsu_stall = 1'b1;
          w_next    = (w_illegal || w_misalign) ? DONE : REQ;
        end
      end
      REQ: begin
        lsu_stall = 1'b1;
        if (w_timeout) begin
          w_next = DONE;
        end else begin
          w_req = 1'b1;
          if (mem.mem_gnt) w_next = r_we ? DONE : WAIT;
        end
      end
      WAIT: begin
        lsu_stall = 1'b1;
        if (w_timeout || mem.mem_rvalid) w_next = DONE;
      end
      DONE: begin
        lsu_done = 1'b1;
        w_next   = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_funct3    <= '0;
      r_addr      <= '0;
      r_data      <= '0;
      r_we        <= 1'b0;
      r_err       <= 1'b0;
      r_load_data <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_funct3    <= ex_funct3;
            r_addr      <= ex_addr;
            r_data      <= ex_store_data;
            r_we        <= ex_mem_write;
            r_err       <= w_illegal;
            r_load_data <= '0;
          end
        end
        REQ: begin
          if (w_timeout) r_err <= 1'b1;
        end
        WAIT: begin
          // Timeout wins over a same-cycle rvalid, so aborted loads return 0.
          if (w_timeout)          r_err       <= 1'b1;
          else if (mem.mem_rvalid) r_load_data <= w_ext;
        end
        default: ;
      endcase
    end
  end

  // Counter restarts on every entry into REQ or WAIT (including REQ->WAIT).
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if ((w_next == REQ || w_next == WAIT) && (w_next != r_state)) begin
      r_cnt <= '0;
    end else if (r_state == REQ || r_state == WAIT) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign lsu_err       = (r_state == DONE) && r_err;
  assign lsu_load_data = (r_state == DONE) ? r_load_data : '0;

  assign mem.mem_req   = w_req;
  assign mem.mem_we    = w_req && r_we;
  assign mem.mem_addr  = w_req ? {r_addr[31:2], 2'b00} : '0;
  assign mem.mem_wstrb = (w_req && r_we) ? store_strb(r_funct3, r_addr[1:0]) : '0;
  assign mem.mem_wdata = (w_req && r_we) ? store_wdata(r_funct3, r_data) : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard testbench for load_store_unit: a driver issues transactions and
// plays the memory, pushing expected bus requests and responses into queues;
// a monitor pops and compares whenever the DUT requests or completes.
module tb_load_store_unit;

  localparam int TMO = 255;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ex_valid = 1'b0;
  logic        ex_mem_read = 1'b0;
  logic        ex_mem_write = 1'b0;
  logic [2:0]  ex_funct3 = '0;
  logic [31:0] ex_addr = '0;
  logic [31:0] ex_store_data = '0;
  logic        lsu_stall;
  logic        lsu_done;
  logic [31:0] lsu_load_data;
  logic        lsu_err;
  logic        lsu_misaligned;

  lsu_if bus ();

  load_store_unit #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk            (clk),
    .reset          (reset),
    .ex_valid       (ex_valid),
    .ex_mem_read    (ex_mem_read),
    .ex_mem_write   (ex_mem_write),
    .ex_funct3      (ex_funct3),
    .ex_addr        (ex_addr),
    .ex_store_data  (ex_store_data),
    .lsu_stall      (lsu_stall),
    .lsu_done       (lsu_done),
    .lsu_load_data  (lsu_load_data),
    .lsu_err        (lsu_err),
    .lsu_misaligned (lsu_misaligned),
    .mem            (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } bus_t;

  typedef struct {
    logic        is_load;
    logic        err;
    logic        mis;
    logic [31:0] data;
  } rsp_t;

  bus_t bus_q[$];
  rsp_t rsp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: byte/half selection by arithmetic on the address.
  function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] w);
    logic [31:0] v;
    case (f3)
      3'd0, 3'd4: begin
        v = (w >> (8 * (a % 4))) & 32'hFF;
        if (f3 == 3'd0 && v >= 32'd128) v = v - 32'd256;
      end
      3'd1, 3'd5: begin
        v = (w >> (16 * ((a / 2) % 2))) & 32'hFFFF;
        if (f3 == 3'd1 && v >= 32'h8000) v = v - 32'h10000;
      end
      default: v = w;
    endcase
    return v;
  endfunction

  function automatic logic [3:0] exp_strb(input logic [2:0] f3, input logic [31:0] a);
    if (f3 == 3'd0) return 4'(1 << (a % 4));
    if (f3 == 3'd1) return 4'(3 << (2 * ((a / 2) % 2)));
    return 4'hF;
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] d);
    if (f3 == 3'd0) return (d & 32'hFF) * 32'h01010101;
    if (f3 == 3'd1) return (d & 32'hFFFF) * 32'h00010001;
    return d;
  endfunction

  // Monitor: compares bus requests and completions against the queues.
  always @(negedge clk) begin : monitor
    bus_t b;
    rsp_t r;
    #1;
    if (!reset) begin
      if (bus.mem_req) begin
        chk("bus_req_expected", 64'(bus_q.size() > 0), 64'd1);
        if (bus_q.size() > 0) begin
          b = bus_q[0];
          chk("bus_we", bus.mem_we, b.we);
          chk("bus_addr", bus.mem_addr, b.addr);
          if (b.we) begin
            chk("bus_wstrb", bus.mem_wstrb, b.strb);
            chk("bus_wdata", bus.mem_wdata, b.wdata);
          end else begin
            chk("bus_wstrb_load", bus.mem_wstrb, 4'h0);
          end
          if (bus.mem_gnt) void'(bus_q.pop_front());
        end
      end
      if (lsu_done) begin
        chk("rsp_expected", 64'(rsp_q.size() > 0), 64'd1);
        chk("stall_in_done", lsu_stall, 1'b0);
        if (rsp_q.size() > 0) begin
          r = rsp_q.pop_front();
          chk("rsp_err", lsu_err, r.err);
          chk("rsp_misaligned", lsu_misaligned, r.mis);
          if (r.is_load || r.err || r.mis) chk("rsp_load_data", lsu_load_data, r.data);
        end
      end
    end
  end

  // gnt_dly < 0: never grant. rv_dly <= 0: never return read data.
  task automatic run_txn(input logic rd, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d, input logic [31:0] rdv,
                         input int gnt_dly, input int rv_dly);
    logic legal, mis;
    bus_t b;
    rsp_t r;
    int   lo, hi, c, req_cyc, since;
    bit   granted, pend;
    legal = rd ? (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5)
               : (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2);
    mis = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    mis = legal && (((f3 == 3'd1 || f3 == 3'd5) && a[0]) || (f3 == 3'd2 && (a % 4) != 0));
`endif
    r.is_load = rd; r.err = 1'b0; r.mis = 1'b0; r.data = '0;
    lo = 1; hi = 1;
    if (!legal) begin
      r.err = 1'b1;
    end else if (mis) begin
      r.mis = 1'b1;
    end else begin
      b.we = !rd; b.addr = a & ~32'h3; b.strb = exp_strb(f3, a); b.wdata = exp_wdata(f3, d);
      bus_q.push_back(b);
      if (gnt_dly < 0) begin
        r.err = 1'b1; lo = TMO + 1; hi = TMO + 3;
      end else if (!rd) begin
        lo = gnt_dly + 2; hi = lo;
      end else if (rv_dly <= 0) begin
        r.err = 1'b1; lo = gnt_dly + 2 + TMO; hi = gnt_dly + 4 + TMO;
      end else begin
        r.data = exp_load(f3, a, rdv); lo = gnt_dly + rv_dly + 2; hi = lo;
      end
    end
    rsp_q.push_back(r);

    @(negedge clk);
    ex_valid = 1'b1; ex_mem_read = rd; ex_mem_write = !rd;
    ex_funct3 = f3; ex_addr = a; ex_store_data = d;
    #1 chk("stall_on_accept", lsu_stall, 1'b1);
    @(posedge clk);
    #1 ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;

    c = 0; req_cyc = 0; since = 0; granted = 1'b0; pend = 1'b0;
    while (c < 700) begin
      @(negedge clk);
      c++;
      bus.mem_gnt = 1'b0;
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata = $urandom;
      if (lsu_done) break;
      chk("stall_busy", lsu_stall, 1'b1);
      if (pend) begin granted = 1'b1; pend = 1'b0; since = 0; end
      if (granted) since++;
      if (bus.mem_req) begin
        if (gnt_dly >= 0 && req_cyc == gnt_dly) begin bus.mem_gnt = 1'b1; pend = 1'b1; end
        req_cyc++;
      end
      if (granted && rv_dly > 0 && since == rv_dly) begin
        bus.mem_rvalid = 1'b1; bus.mem_rdata = rdv;
      end
    end
    chk("done_seen", lsu_done, 1'b1);
    if (lo == hi) chk("latency", 64'(c), 64'(lo));
    else          chk("latency_window", 64'(c >= lo && c <= hi), 64'd1);
    if (legal && !mis && gnt_dly < 0) bus_q.delete();
  endtask

  logic [2:0] ld_f3[5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
  logic [2:0] st_f3[3] = '{3'd0, 3'd1, 3'd2};

  initial begin
    logic       rd;
    logic [2:0] f3;
    bus_t       b;
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
    repeat (3) @(negedge clk);
    chk("reset_ctrl", {lsu_stall, lsu_done, lsu_err, lsu_misaligned,
                       bus.mem_req, bus.mem_we, bus.mem_wstrb}, '0);
    chk("reset_data", {lsu_load_data, bus.mem_addr}, '0);
    reset = 1'b0;

    // Directed cases
    run_txn(1'b0, 3'd0, 32'h0000_1003, 32'h0000_00A5, 32'h0, 0, 1);   // SB
    run_txn(1'b1, 3'd0, 32'h0000_2002, 32'h0, 32'h12F0_3456, 0, 1);   // LB
    run_txn(1'b1, 3'd4, 32'h0000_2002, 32'h0, 32'h12F0_3456, 0, 1);   // LBU
    run_txn(1'b1, 3'd1, 32'h0000_2002, 32'h0, 32'h8001_0000, 4, 1);   // LH, slow gnt
    run_txn(1'b1, 3'd2, 32'h0000_3001, 32'h0, 32'hCAFE_F00D, 0, 2);   // LW misaligned
    run_txn(1'b1, 3'd3, 32'h0000_3000, 32'h0, 32'h0, 0, 1);           // illegal load
    run_txn(1'b0, 3'd4, 32'h0000_3000, 32'h0, 32'h0, 0, 1);           // SBU is illegal
    run_txn(1'b1, 3'd2, 32'h0000_5000, 32'h0, 32'h0, 0, 0);           // WAIT timeout
    run_txn(1'b0, 3'd2, 32'h0000_5004, 32'h1234_5678, 32'h0, -1, 0);  // REQ timeout

    // Reset while waiting for read data, then a stray rvalid
    b.we = 1'b0; b.addr = 32'h0000_4000; b.strb = '0; b.wdata = '0;
    bus_q.push_back(b);
    @(negedge clk);
    ex_valid = 1'b1; ex_mem_read = 1'b1; ex_funct3 = 3'd2; ex_addr = 32'h0000_4000;
    @(posedge clk);
    #1 ex_valid = 1'b0; ex_mem_read = 1'b0;
    @(negedge clk);
    bus.mem_gnt = 1'b1;
    @(negedge clk);
    bus.mem_gnt = 1'b0;
    chk("stall_in_wait", lsu_stall, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    chk("midreset_ctrl", {lsu_stall, lsu_done, lsu_err, lsu_misaligned,
                          bus.mem_req, bus.mem_we, bus.mem_wstrb}, '0);
    chk("midreset_data", {lsu_load_data, bus.mem_addr}, '0);
    reset = 1'b0;
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.mem_rvalid = 1'b0;
    repeat (4) begin
      chk("no_done_after_reset", lsu_done, 1'b0);
      chk("no_req_after_reset", bus.mem_req, 1'b0);
      @(negedge clk);
    end
    run_txn(1'b1, 3'd5, 32'h0000_4002, 32'h0, 32'h9ABC_1234, 1, 3);   // LHU after reset

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      rd = 1'($urandom % 2);
      if ($urandom % 5 == 0) f3 = 3'($urandom % 8);
      else if (rd)           f3 = ld_f3[$urandom % 5];
      else                   f3 = st_f3[$urandom % 3];
      run_txn(rd, f3, $urandom, $urandom, $urandom, int'($urandom % 5), int'(1 + $urandom % 4));
    end

    repeat (3) @(negedge clk);
    chk("rsp_queue_drained", 64'(rsp_q.size()), 64'd0);
    chk("bus_queue_drained", 64'(bus_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (compared %0d)", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
